s2_stream_reader: RTL and testbench
===================================

# s2_stream_reader

Read initiator for the exported second (s2) port of a Qsys on-chip dual-port RAM, such as the FIR coefficient, interpolator or adaptive-filter memories. On a start pulse it issues a burst of sequential single-word reads from a base address. It returns the words on a valid/ready stream with backpressure, and it never overruns its internal buffer. It sits in the fabric between the s2 port and a filter datapath that consumes coefficients or samples.

## Interface
- ADDR_W, 10: s2 word-address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 32: s2 data width. Byte enables are DATA_W/8 wide.
- READ_LATENCY, 1: RAM read latency in cycles. Legal values are 1 and 2; other values are a synthesis error.
- FIFO_DEPTH, 4: output buffer depth, power of two, ≥ READ_LATENCY+1.
- clk_clk  in  1  single clock for all logic, same clock as the RAM s2 clock.
- reset_reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; captured on an accepted start.
- count  in  ADDR_W+1  number of words to read; captured on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the final word has been handed off.
- s2_address  out  ADDR_W  read address.
- s2_chipselect  out  1  read strobe, one cycle per word.
- s2_clken  out  1  tied to 1.
- s2_write  out  1  tied to 0.
- s2_writedata  out  DATA_W  tied to 0.
- s2_byteenable  out  DATA_W/8  all ones.
- s2_readdata  in  DATA_W  read data, valid READ_LATENCY cycles after a strobe.
- out_data  out  DATA_W  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  consumer ready.
- out_last  out  1  marks the final word of the burst; qualified by out_valid.

## Operation
- The state machine has three states: IDLE, ISSUE, DRAIN.
- **IDLE**
  - start with count≠0: latch base_addr as the issue pointer, latch count, go to ISSUE.
  - start with count=0: go straight to a done pulse; no s2 strobe is issued.
- **ISSUE**
  - A read is issued (s2_chipselect=1, s2_address=pointer) when all of these hold:
    - remaining>0;
    - in_flight + fifo_occupancy < FIFO_DEPTH, where in_flight is the number of reads issued whose data has not yet returned.
  - On each issue the pointer increments by 1 and wraps from 2^ADDR_W−1 to 0. remaining decrements by 1.
  - When the last read has been issued, go to DRAIN.
- **DRAIN**
  - Wait until in_flight=0 and the FIFO is empty, with the final word accepted.
  - Then pulse done and return to IDLE.
- **Return path**
  - A READ_LATENCY-deep valid shift register tags each strobe.
  - On the tagged cycle, s2_readdata is written into the FIFO together with a last flag. The last flag is set when that word was the final one issued.
  - The credit rule guarantees the FIFO never overflows; it is a design invariant and is asserted in simulation.
- **Stream rules**
  - out_data, out_last and out_valid hold stable while out_valid=1 and out_ready=0.
  - A handshake occurs when out_valid & out_ready.
- **Other rules**
  - start is ignored while busy=1.
  - count and base_addr are not re-sampled mid-burst.
  - Reset mid-burst: on the next edge with reset_reset_n=0, all state clears, in-flight data is discarded and the FIFO empties. No done pulse is generated.
  - Reset values: busy=0, done=0, s2_chipselect=0, s2_address=0, out_valid=0, out_last=0, out_data=0.

## Timing
- Cycle 0: start accepted.
- Cycle 1: busy=1 and the first strobe, at base_addr.
- Cycle 1+READ_LATENCY: first readdata.
- Cycle 2+READ_LATENCY: first out_valid.
- With out_ready held high, strobes and out_valid run back-to-back at one word per cycle.
- An N-word burst at full rate ends its final handshake at cycle N+1+READ_LATENCY.
- done pulses, and busy falls, on the cycle after the final handshake.
- count=0: done pulses on cycle 1; busy stays 0.
- A start is accepted in the same cycle that done is high.
- After out_ready deasserts, strobes stop as soon as credits run out. At most FIFO_DEPTH words are buffered or in flight.

## Test plan
- **Basic burst:** READ_LATENCY=1, base=0x010, count=8, out_ready=1, RAM[a]=a*3.
  - Expect strobes on cycles 1–8 at 0x010..0x017.
  - Expect out_valid on cycles 3–10 with data 0x30..0x45.
  - Expect out_last on the 8th word and done on cycle 11.
- **Address wrap:** base=0x3FE, count=4.
  - Expect addresses 0x3FE, 0x3FF, 0x000, 0x001.
  - Expect 4 words in order, last on the 4th.
- **Backpressure:** count=16, out_ready toggled 1 cycle high / 3 cycles low, READ_LATENCY=2.
  - Expect no lost or duplicated words.
  - Expect in_flight+occupancy ≤ 4 at all times and data held stable while stalled.
- **Zero-count start:** count=0.
  - Expect no s2_chipselect, done on cycle 1 and busy=0 throughout.
- **Ignored start:** pulse start again mid-burst with different base/count.
  - Expect the original burst to complete unchanged.
  - Expect exactly one done pulse.
- **Reset mid-burst:** assert reset_reset_n=0 for one cycle after the 5th of 10 handshakes.
  - Expect all outputs at reset values the next cycle and no done pulse.
  - A new start=1, count=2 then completes normally.

Source files
------------

// File: rtl/s2_stream_reader.sv
// s2_stream_reader: burst read initiator for the s2 port of an on-chip dual-port RAM.
// A start pulse launches a run of sequential single-word reads. Returned words are
// buffered and presented on a valid/ready stream. Reads are only issued while the
// buffer has room for every outstanding word, so backpressure can never overflow it.
module s2_stream_reader #(
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     count,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   s2_address,
   output logic                s2_chipselect,
   output logic                s2_clken,
   output logic                s2_write,
   output logic [DATA_W-1:0]   s2_writedata,
   output logic [DATA_W/8-1:0] s2_byteenable,
   input  logic [DATA_W-1:0]   s2_readdata,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam int unsigned REM_W = ADDR_W + 1;

   localparam logic [SUM_W-1:0] DEPTH_C   = SUM_W'(FIFO_DEPTH);
   localparam logic [REM_W-1:0] REM_ONE_C = REM_W'(1);
   localparam logic [CNT_W-1:0] OCC_ONE_C = CNT_W'(1);

   // Reject parameter sets the return path cannot support.
   if (READ_LATENCY == 0 || READ_LATENCY > 2) begin : g_bad_latency
      $error("s2_stream_reader: READ_LATENCY must be 1 or 2");
   end
   if (FIFO_DEPTH < READ_LATENCY + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("s2_stream_reader: FIFO_DEPTH must be a power of two >= READ_LATENCY+1");
   end

   typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

   state_e                  r_state;
   state_e                  w_state_nxt;
   logic                    r_done;
   logic                    w_done_nxt;
   logic                    w_accept;

   logic [ADDR_W-1:0]       r_ptr;
   logic [REM_W-1:0]        r_remaining;

   // Strobe tags: bit READ_LATENCY-1 lines up with the cycle s2_readdata is valid.
   logic [READ_LATENCY-1:0] r_vld_sr;
   logic [READ_LATENCY-1:0] r_last_sr;

   logic [DATA_W-1:0]       r_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]   r_mem_last;
   logic [PTR_W-1:0]        r_wr_ptr;
   logic [PTR_W-1:0]        r_rd_ptr;
   logic [CNT_W-1:0]        r_occ;

   logic [CNT_W-1:0]        w_in_flight;
   logic                    w_credit_ok;
   logic                    w_issue;
   logic                    w_issue_last;
   logic                    w_fifo_wr;
   logic                    w_pop;
   logic                    w_final_hs;

   // Count reads whose data is still travelling back from the RAM.
   always_comb begin
      w_in_flight = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         w_in_flight = w_in_flight + CNT_W'(r_vld_sr[i]);
      end
   end

   // A read is allowed only if the buffer can absorb it alongside everything outstanding.
   assign w_credit_ok  = ({1'b0, w_in_flight} + {1'b0, r_occ}) < DEPTH_C;
   assign w_issue      = (r_state == StIssue) && (r_remaining != '0) && w_credit_ok;
   assign w_issue_last = w_issue && (r_remaining == REM_ONE_C);
   assign w_fifo_wr    = r_vld_sr[READ_LATENCY-1];
   assign w_pop        = out_valid && out_ready;
   // Final word leaves the buffer with nothing behind it.
   assign w_final_hs   = w_pop && r_mem_last[r_rd_ptr] && (r_occ == OCC_ONE_C)
                         && (w_in_flight == '0);

   // State register and done pulse.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_state <= StIdle;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next-state logic; a zero-length request completes without leaving IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      w_accept    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               if (count == '0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_accept    = 1'b1;
                  w_state_nxt = StIssue;
               end
            end
         end
         StIssue: begin
            if (w_issue_last) begin
               w_state_nxt = StDrain;
            end
         end
         StDrain: begin
            if (w_final_hs) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Address pointer and remaining-word counter; only loaded from the inputs in IDLE.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_ptr       <= '0;
         r_remaining <= '0;
      end else if (w_accept) begin
         r_ptr       <= base_addr;
         r_remaining <= count;
      end else if (w_issue) begin
         r_ptr       <= r_ptr + ADDR_W'(1);
         r_remaining <= r_remaining - REM_ONE_C;
      end
   end

   // Tag each strobe (and whether it is the last) as it travels through the RAM pipeline.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_vld_sr  <= '0;
         r_last_sr <= '0;
      end else begin
         r_vld_sr[0]  <= w_issue;
         r_last_sr[0] <= w_issue_last;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_vld_sr[i]  <= r_vld_sr[i-1];
            r_last_sr[i] <= r_last_sr[i-1];
         end
      end
   end

   // Buffer pointers and occupancy.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_fifo_wr) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_fifo_wr, w_pop})
            2'b10:   r_occ <= r_occ + OCC_ONE_C;
            2'b01:   r_occ <= r_occ - OCC_ONE_C;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Buffer storage; contents are don't-care while unoccupied, so no reset is needed.
   always_ff @(posedge clk_clk) begin
      if (w_fifo_wr) begin
         r_mem[r_wr_ptr]      <= s2_readdata;
         r_mem_last[r_wr_ptr] <= r_last_sr[READ_LATENCY-1];
      end
   end

   // The credit scheme must always leave room for a returning word.
   assert property (@(posedge clk_clk) disable iff (!reset_reset_n)
                    w_fifo_wr |-> (({1'b0, r_occ} < DEPTH_C) || w_pop));

   assign busy          = (r_state != StIdle);
   assign done          = r_done;
   assign s2_address    = r_ptr;
   assign s2_chipselect = w_issue;
   assign s2_clken      = 1'b1;
   assign s2_write      = 1'b0;
   assign s2_writedata  = '0;
   assign s2_byteenable = '1;

   // Stream outputs are gated by valid so stale buffer contents never show.
   assign out_valid = (r_occ != '0);
   assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
   assign out_last  = out_valid & r_mem_last[r_rd_ptr];

endmodule

// File: tb/tb_s2_stream_reader.sv
// Directed bench for s2_stream_reader: instance A uses READ_LATENCY=1, instance B
// READ_LATENCY=2; both share stimulus and each has its own RAM model (RAM[a] = a*3).
module tb_s2_stream_reader;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W:0]   cnt;
   logic              out_ready;

   logic              a_busy, a_done, a_cs, a_clken, a_write, a_valid, a_last;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata, a_rdata, a_data;
   logic [3:0]        a_be;

   logic              b_busy, b_done, b_cs, b_clken, b_write, b_valid, b_last;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata, b_rdata, b_pipe, b_data;
   logic [3:0]        b_be;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] ram_val(input logic [ADDR_W-1:0] a);
      return DATA_W'(a) * 3;
   endfunction

   // RAM models: latency 1 for A, latency 2 for B.
   always @(posedge clk) a_rdata <= ram_val(a_addr);
   always @(posedge clk) begin
      b_pipe  <= ram_val(b_addr);
      b_rdata <= b_pipe;
   end

   s2_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1), .FIFO_DEPTH(4)) u_dut_a (
      .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .base_addr(base), .count(cnt),
      .busy(a_busy), .done(a_done), .s2_address(a_addr), .s2_chipselect(a_cs),
      .s2_clken(a_clken), .s2_write(a_write), .s2_writedata(a_wdata), .s2_byteenable(a_be),
      .s2_readdata(a_rdata), .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
      .out_last(a_last)
   );

   s2_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(2), .FIFO_DEPTH(4)) u_dut_b (
      .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .base_addr(base), .count(cnt),
      .busy(b_busy), .done(b_done), .s2_address(b_addr), .s2_chipselect(b_cs),
      .s2_clken(b_clken), .s2_write(b_write), .s2_writedata(b_wdata), .s2_byteenable(b_be),
      .s2_readdata(b_rdata), .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready),
      .out_last(b_last)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      start     = 1'b0;
      out_ready = 1'b1;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; base = '0; cnt = '0; out_ready = 1'b1;
      repeat (3) tick();
      n_checks++; if ({a_busy, a_done, a_cs, a_valid, a_last} !== 5'b0) begin
         n_fail++; $display("FAIL reset_ctrl_a got=%b exp=00000", {a_busy, a_done, a_cs, a_valid, a_last}); end
      n_checks++; if ({b_busy, b_done, b_cs, b_valid, b_last} !== 5'b0) begin
         n_fail++; $display("FAIL reset_ctrl_b got=%b exp=00000", {b_busy, b_done, b_cs, b_valid, b_last}); end
      n_checks++; if (a_addr !== 10'h000) begin n_fail++; $display("FAIL reset_addr_a got=%h exp=000", a_addr); end
      n_checks++; if (b_addr !== 10'h000) begin n_fail++; $display("FAIL reset_addr_b got=%h exp=000", b_addr); end
      n_checks++; if (a_data !== 32'h0) begin n_fail++; $display("FAIL reset_data_a got=%h exp=0", a_data); end
      n_checks++; if (b_data !== 32'h0) begin n_fail++; $display("FAIL reset_data_b got=%h exp=0", b_data); end
      n_checks++; if ({a_clken, a_write} !== 2'b10) begin n_fail++; $display("FAIL tie_clken_write_a got=%b exp=10", {a_clken, a_write}); end
      n_checks++; if ({b_clken, b_write} !== 2'b10) begin n_fail++; $display("FAIL tie_clken_write_b got=%b exp=10", {b_clken, b_write}); end
      n_checks++; if (a_wdata !== 32'h0) begin n_fail++; $display("FAIL tie_wdata_a got=%h exp=0", a_wdata); end
      n_checks++; if (a_be !== 4'hF) begin n_fail++; $display("FAIL tie_be_a got=%h exp=f", a_be); end
      n_checks++; if (b_be !== 4'hF) begin n_fail++; $display("FAIL tie_be_b got=%h exp=f", b_be); end
      rst_n = 1'b1;
      tick();
   endtask

   // RL=1, base 0x010, count 8, ready held high: exact cycle timing.
   task automatic test_basic_burst();
      out_ready = 1'b1; base = 10'h010; cnt = 11'd8; start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         start = 1'b0;
         n_checks++; if (a_cs !== (c <= 8)) begin
            n_fail++; $display("FAIL basic_cs c=%0d got=%b exp=%b", c, a_cs, (c <= 8)); end
         if (c <= 8) begin
            n_checks++; if (a_addr !== ADDR_W'(32'h10 + c - 1)) begin
               n_fail++; $display("FAIL basic_addr c=%0d got=%h exp=%h", c, a_addr, 32'h10 + c - 1); end
         end
         n_checks++; if (a_valid !== (c >= 3 && c <= 10)) begin
            n_fail++; $display("FAIL basic_valid c=%0d got=%b exp=%b", c, a_valid, (c >= 3 && c <= 10)); end
         if (c >= 3 && c <= 10) begin
            n_checks++; if (a_data !== DATA_W'((32'h10 + c - 3) * 3)) begin
               n_fail++; $display("FAIL basic_data c=%0d got=%h exp=%h", c, a_data, (32'h10 + c - 3) * 3); end
            n_checks++; if (a_last !== (c == 10)) begin
               n_fail++; $display("FAIL basic_last c=%0d got=%b exp=%b", c, a_last, (c == 10)); end
         end
         n_checks++; if (a_done !== (c == 11)) begin
            n_fail++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, a_done, (c == 11)); end
         n_checks++; if (a_busy !== (c <= 10)) begin
            n_fail++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, a_busy, (c <= 10)); end
      end
      idle(4);
   endtask

   task automatic test_addr_wrap();
      logic [ADDR_W-1:0] exp_addr [4];
      logic [DATA_W-1:0] exp_data [4];
      int ni = 0;
      int nh = 0;
      exp_addr[0] = 10'h3FE; exp_addr[1] = 10'h3FF; exp_addr[2] = 10'h000; exp_addr[3] = 10'h001;
      exp_data[0] = 32'hBFA; exp_data[1] = 32'hBFD; exp_data[2] = 32'h000; exp_data[3] = 32'h003;
      out_ready = 1'b1; base = 10'h3FE; cnt = 11'd4; start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         start = 1'b0;
         if (a_cs) begin
            n_checks++;
            if (ni >= 4) begin n_fail++; $display("FAIL wrap_extra_strobe got=%h exp=none", a_addr); end
            else if (a_addr !== exp_addr[ni]) begin
               n_fail++; $display("FAIL wrap_addr n=%0d got=%h exp=%h", ni, a_addr, exp_addr[ni]); end
            ni++;
         end
         if (a_valid && out_ready) begin
            n_checks++;
            if (nh >= 4) begin n_fail++; $display("FAIL wrap_extra_word got=%h exp=none", a_data); end
            else if ({a_last, a_data} !== {(nh == 3), exp_data[nh]}) begin
               n_fail++; $display("FAIL wrap_word n=%0d got=%b/%h exp=%b/%h", nh, a_last, a_data, (nh == 3), exp_data[nh]); end
            nh++;
         end
      end
      n_checks++; if (ni != 4) begin n_fail++; $display("FAIL wrap_strobe_count got=%0d exp=4", ni); end
      n_checks++; if (nh != 4) begin n_fail++; $display("FAIL wrap_word_count got=%0d exp=4", nh); end
      idle(4);
   endtask

   // RL=2 instance, ready high 1 cycle of every 4.
   task automatic test_backpressure();
      int ni = 0;
      int nh = 0;
      int nd = 0;
      logic              p_valid = 1'b0;
      logic              p_ready = 1'b0;
      logic              p_last  = 1'b0;
      logic [DATA_W-1:0] p_data  = '0;
      base = 10'h100; cnt = 11'd16; start = 1'b1; out_ready = 1'b0;
      for (int c = 1; c <= 200 && nd == 0; c++) begin
         tick();
         start     = 1'b0;
         out_ready = (c % 4 == 0);
         if (b_cs) begin
            ni++;
            n_checks++; if (ni - nh > 4) begin
               n_fail++; $display("FAIL bp_outstanding c=%0d got=%0d exp<=4", c, ni - nh); end
         end
         if (p_valid && !p_ready) begin
            n_checks++; if ({b_valid, b_last, b_data} !== {1'b1, p_last, p_data}) begin
               n_fail++; $display("FAIL bp_stable c=%0d got=%b/%b/%h exp=1/%b/%h", c, b_valid, b_last, b_data, p_last, p_data); end
         end
         if (b_valid && out_ready) begin
            n_checks++; if ({b_last, b_data} !== {(nh == 15), ram_val(ADDR_W'(32'h100 + nh))}) begin
               n_fail++; $display("FAIL bp_word n=%0d got=%b/%h exp=%b/%h", nh, b_last, b_data, (nh == 15), ram_val(ADDR_W'(32'h100 + nh))); end
            nh++;
         end
         if (b_done) nd++;
         p_valid = b_valid; p_ready = out_ready; p_last = b_last; p_data = b_data;
      end
      n_checks++; if (nd != 1) begin n_fail++; $display("FAIL bp_done got=%0d exp=1", nd); end
      n_checks++; if (nh != 16) begin n_fail++; $display("FAIL bp_word_count got=%0d exp=16", nh); end
      n_checks++; if (ni != 16) begin n_fail++; $display("FAIL bp_strobe_count got=%0d exp=16", ni); end
      idle(8);
   endtask

   task automatic test_zero_count();
      out_ready = 1'b1; base = 10'h123; cnt = 11'd0; start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         start = 1'b0;
         n_checks++; if ({a_cs, a_busy, a_done} !== {2'b00, (c == 1)}) begin
            n_fail++; $display("FAIL zero_a c=%0d got=%b exp=00%b", c, {a_cs, a_busy, a_done}, (c == 1)); end
         n_checks++; if ({b_cs, b_busy, b_done} !== {2'b00, (c == 1)}) begin
            n_fail++; $display("FAIL zero_b c=%0d got=%b exp=00%b", c, {b_cs, b_busy, b_done}, (c == 1)); end
      end
      idle(2);
   endtask

   task automatic test_ignored_start();
      int ni = 0;
      int nh = 0;
      int nd = 0;
      out_ready = 1'b1; base = 10'h020; cnt = 11'd6; start = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         tick();
         start = 1'b0;
         if (a_cs) begin
            n_checks++; if (a_addr !== ADDR_W'(32'h20 + ni)) begin
               n_fail++; $display("FAIL ign_addr n=%0d got=%h exp=%h", ni, a_addr, 32'h20 + ni); end
            ni++;
         end
         if (a_valid && out_ready) begin
            n_checks++; if ({a_last, a_data} !== {(nh == 5), ram_val(ADDR_W'(32'h20 + nh))}) begin
               n_fail++; $display("FAIL ign_word n=%0d got=%b/%h exp=%b/%h", nh, a_last, a_data, (nh == 5), ram_val(ADDR_W'(32'h20 + nh))); end
            nh++;
         end
         if (a_done) nd++;
         if (c == 3) begin
            start = 1'b1; base = 10'h200; cnt = 11'd3;
         end
      end
      n_checks++; if (ni != 6) begin n_fail++; $display("FAIL ign_strobe_count got=%0d exp=6", ni); end
      n_checks++; if (nh != 6) begin n_fail++; $display("FAIL ign_word_count got=%0d exp=6", nh); end
      n_checks++; if (nd != 1) begin n_fail++; $display("FAIL ign_done_count got=%0d exp=1", nd); end
      idle(4);
   endtask

   task automatic test_reset_mid_burst();
      int nh = 0;
      int nd = 0;
      out_ready = 1'b1; base = 10'h040; cnt = 11'd10; start = 1'b1;
      for (int c = 1; c <= 20 && nh < 5; c++) begin
         tick();
         start = 1'b0;
         if (a_done) nd++;
         if (a_valid && out_ready) nh++;
      end
      n_checks++; if (nh != 5) begin n_fail++; $display("FAIL rst_reach_5th got=%0d exp=5", nh); end
      tick();
      if (a_done) nd++;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_checks++; if ({a_busy, a_done, a_cs, a_valid, a_last} !== 5'b0) begin
         n_fail++; $display("FAIL rst_mid_ctrl got=%b exp=00000", {a_busy, a_done, a_cs, a_valid, a_last}); end
      n_checks++; if ({a_addr, a_data} !== {10'h000, 32'h0}) begin
         n_fail++; $display("FAIL rst_mid_addr_data got=%h/%h exp=000/0", a_addr, a_data); end
      n_checks++; if ({b_busy, b_valid, b_cs} !== 3'b0) begin
         n_fail++; $display("FAIL rst_mid_b got=%b exp=000", {b_busy, b_valid, b_cs}); end
      for (int c = 0; c < 4; c++) begin
         tick();
         if (a_done) nd++;
         n_checks++; if ({a_valid, a_cs} !== 2'b00) begin
            n_fail++; $display("FAIL rst_quiet c=%0d got=%b exp=00", c, {a_valid, a_cs}); end
      end
      n_checks++; if (nd != 0) begin n_fail++; $display("FAIL rst_no_done got=%0d exp=0", nd); end
      nh = 0;
      base = 10'h050; cnt = 11'd2; start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         start = 1'b0;
         if (a_valid && out_ready) begin
            n_checks++; if ({a_last, a_data} !== {(nh == 1), ram_val(ADDR_W'(32'h50 + nh))}) begin
               n_fail++; $display("FAIL rst_after_word n=%0d got=%b/%h exp=%b/%h", nh, a_last, a_data, (nh == 1), ram_val(ADDR_W'(32'h50 + nh))); end
            nh++;
         end
         if (a_done) nd++;
      end
      n_checks++; if (nh != 2) begin n_fail++; $display("FAIL rst_after_count got=%0d exp=2", nh); end
      n_checks++; if (nd != 1) begin n_fail++; $display("FAIL rst_after_done got=%0d exp=1", nd); end
      idle(4);
   endtask

   // A new start in the same cycle as done must be accepted.
   task automatic test_back_to_back();
      bit seen = 1'b0;
      out_ready = 1'b1; base = 10'h060; cnt = 11'd2; start = 1'b1;
      for (int c = 1; c <= 20 && !seen; c++) begin
         tick();
         start = 1'b0;
         if (a_done) begin
            seen  = 1'b1;
            start = 1'b1; base = 10'h070; cnt = 11'd1;
         end
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL b2b_done_timeout got=0 exp=1"); end
      tick();
      start = 1'b0;
      n_checks++; if ({a_busy, a_cs, a_addr} !== {2'b11, 10'h070}) begin
         n_fail++; $display("FAIL b2b_restart got=%b/%b/%h exp=1/1/070", a_busy, a_cs, a_addr); end
      idle(8);
      n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_finish got=%b exp=0", a_busy); end
   endtask

   initial begin
      test_reset();
      test_basic_burst();
      test_addr_wrap();
      test_backpressure();
      test_zero_count();
      test_ignored_start();
      test_reset_mid_burst();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
